// File: rtl/prng_lfsr_gen_if.sv
// Output word handshake between the PRNG and its consumer.
// The generator drives the word and its valid flag; the consumer answers with ready.
interface prng_lfsr_gen_if #(
    parameter int OUT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/prng_lfsr_gen.sv
// Pseudo-random word generator.
// A WIDTH-bit XNOR Fibonacci data LFSR and an 8-bit XNOR control LFSR feed a
// bit-pair selector. Steps come from an on-clock prescaler (mode 0) or from an
// external strobe (mode 1). The output word is offered on a valid/ready
// handshake, and overwriting an unaccepted word raises a sticky overrun flag.
module prng_lfsr_gen #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hD008,
    parameter logic [7:0]       CTRL_TAPS  = 8'hB8,
    parameter int               OUT_W      = 8,
    parameter int               DIV        = 10_000_000,
    parameter int               CTRL_RATIO = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic              mode_i,
    input  logic              step_i,
    input  logic              seed_load_i,
    input  logic [WIDTH-1:0]  seed_in_i,
    prng_lfsr_gen_if.master   out_if,
    output logic              tick_out_o,
    output logic              overrun_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = (CTRL_RATIO > 1) ? $clog2(CTRL_RATIO) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [RW-1:0] RATIO_LAST = RW'(CTRL_RATIO - 1);

    logic [WIDTH-1:0] data_q,    data_d;
    logic [7:0]       ctrl_q,    ctrl_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic [RW-1:0]    ratio_q,   ratio_d;
    logic [OUT_W-1:0] word_q,    word_d;
    logic             valid_q,   valid_d;
    logic             tick_q,    tick_d;
    logic             overrun_q, overrun_d;
    logic             wrap;
    logic             step_req;

    // The tapped bits are XNOR-reduced and shifted in at bit 0; all-ones locks up.
    function automatic logic [WIDTH-1:0] dataNext(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ~^(s & TAPS)};
    endfunction

    function automatic logic [7:0] ctrlNext(input logic [7:0] s);
        return {s[6:0], ~^(s & CTRL_TAPS)};
    endfunction

    // Each output bit picks one bit of its data pair, steered by a control bit.
    function automatic logic [OUT_W-1:0] selectWord(input logic [WIDTH-1:0] s,
                                                    input logic [7:0]       c);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w[i] = c[i] ? s[2*i+1] : s[2*i];
        end
        return w;
    endfunction

    // Next-state logic: ena low freezes everything, then seed load beats step beats accept.
    always_comb begin
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        ratio_d   = ratio_q;
        word_d    = word_q;
        valid_d   = valid_q;
        tick_d    = tick_q;
        overrun_d = overrun_q;
        wrap      = 1'b0;
        step_req  = 1'b0;

        if (ena_i) begin
            wrap     = (presc_q == PRESC_LAST);
            presc_d  = wrap ? '0 : presc_q + PW'(1);
            tick_d   = wrap;
            step_req = mode_i ? step_i : wrap;

            if (seed_load_i) begin
                data_d    = (seed_in_i == '1) ? '0 : seed_in_i;
                ctrl_d    = '0;
                ratio_d   = '0;
                overrun_d = 1'b0;
                valid_d   = 1'b0;
            end else if (step_req) begin
                data_d = dataNext(data_q);
                if (ratio_q == RATIO_LAST) begin
                    ratio_d = '0;
                    ctrl_d  = ctrlNext(ctrl_q);
                end else begin
                    ratio_d = ratio_q + RW'(1);
                end
                word_d = selectWord(data_d, ctrl_d);
                if (valid_q && !out_if.out_ready) begin
                    overrun_d = 1'b1;
                end
                valid_d = 1'b1;
            end else if (valid_q && out_if.out_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q    <= '0;
            ctrl_q    <= '0;
            presc_q   <= '0;
            ratio_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            tick_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            ratio_q   <= ratio_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            tick_q    <= tick_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.out_data  = word_q;
    assign out_if.out_valid = valid_q;
    assign tick_out_o       = tick_q;
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_prng_lfsr_gen.sv
// Self-checking bench for prng_lfsr_gen: directed scenarios followed by
// randomized stimulus, all compared cycle by cycle against a behavioural model.
module tb_prng_lfsr_gen;

    localparam int DIV        = 4;
    localparam int CTRL_RATIO = 4;
    localparam int DTAPS      = 'hD008;
    localparam int CTAPS      = 'hB8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        mode;
    logic        step;
    logic        seedLoad;
    logic [15:0] seedIn;
    logic        tickOut;
    logic        overrun;

    int nVectors     = 0;
    int nMiscompares = 0;

    int mData, mCtrl, mPresc, mRatio, mWord;
    int mValid, mTick, mOver;

    logic [15:0] expState [4] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
    logic [7:0]  expWord  [4] = '{8'h01, 8'h01, 8'h03, 8'h03};
    logic [7:0]  heldWord;
    logic        heldValid;
    logic        heldOver;

    prng_lfsr_gen_if #(.OUT_W(8)) outBus ();

    prng_lfsr_gen #(
        .WIDTH(16), .TAPS(16'hD008), .CTRL_TAPS(8'hB8), .OUT_W(8),
        .DIV(DIV), .CTRL_RATIO(CTRL_RATIO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena_i(ena),
        .mode_i(mode),
        .step_i(step),
        .seed_load_i(seedLoad),
        .seed_in_i(seedIn),
        .out_if(outBus),
        .tick_out_o(tickOut),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    // Parity of tapped bits decides the feedback: even count of ones shifts in a 1.
    function automatic int lfsrStep(input int s, input int width, input int taps);
        int cnt = 0;
        for (int i = 0; i < width; i++) begin
            if (((s >> i) & 1) == 1 && ((taps >> i) & 1) == 1) cnt++;
        end
        return ((s << 1) | ((cnt % 2 == 0) ? 1 : 0)) & ((1 << width) - 1);
    endfunction

    function automatic int pickWord(input int d, input int c);
        int w = 0;
        for (int i = 0; i < 8; i++) begin
            if (((c >> i) & 1) == 1) w |= ((d >> (2*i+1)) & 1) << i;
            else                     w |= ((d >> (2*i)) & 1) << i;
        end
        return w;
    endfunction

    // Behavioural reaction of the generator to the inputs present at one clock edge.
    task automatic modelEdge();
        int wrapNow, stepNow;
        if (!rst_n) begin
            mData = 0; mCtrl = 0; mPresc = 0; mRatio = 0;
            mWord = 0; mValid = 0; mTick = 0; mOver = 0;
        end else if (ena) begin
            wrapNow = (mPresc == DIV - 1);
            mPresc  = wrapNow ? 0 : mPresc + 1;
            mTick   = wrapNow;
            stepNow = mode ? int'(step) : wrapNow;
            if (seedLoad) begin
                mData  = (seedIn == 16'hFFFF) ? 0 : int'(seedIn);
                mCtrl  = 0; mRatio = 0; mOver = 0; mValid = 0;
            end else if (stepNow != 0) begin
                mData  = lfsrStep(mData, 16, DTAPS);
                mRatio = mRatio + 1;
                if (mRatio == CTRL_RATIO) begin
                    mRatio = 0;
                    mCtrl  = lfsrStep(mCtrl, 8, CTAPS);
                end
                mWord = pickWord(mData, mCtrl);
                if (mValid == 1 && !outBus.out_ready) mOver = 1;
                mValid = 1;
            end else if (mValid == 1 && outBus.out_ready) begin
                mValid = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: the model reacts at the edge, the DUT is sampled 1 ns later.
    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("valid",   32'(outBus.out_valid), 32'(mValid));
        checkOutput("data",    32'(outBus.out_data),  32'(mWord));
        checkOutput("tick",    32'(tickOut),          32'(mTick));
        checkOutput("overrun", 32'(overrun),          32'(mOver));
        checkOutput("state",   32'(dut.data_q),       32'(mData));
        checkOutput("ctrl",    32'(dut.ctrl_q),       32'(mCtrl));
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; mode = 1'b1; step = 1'b0;
        seedLoad = 1'b0; seedIn = 16'h0000; outBus.out_ready = 1'b0;
        mData = 0; mCtrl = 0; mPresc = 0; mRatio = 0;
        mWord = 0; mValid = 0; mTick = 0; mOver = 0;

        // Reset state.
        applyStimulus();
        applyStimulus();
        checkOutput("rst_valid", 32'(outBus.out_valid), 32'h0);
        checkOutput("rst_data",  32'(outBus.out_data),  32'h0);
        checkOutput("rst_tick",  32'(tickOut),          32'h0);
        checkOutput("rst_over",  32'(overrun),          32'h0);

        // First four strobe steps from the zero state.
        rst_n = 1'b1;
        outBus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step = 1'b1;
            applyStimulus();
            checkOutput("seq_state", 32'(dut.data_q),       32'(expState[k]));
            checkOutput("seq_word",  32'(outBus.out_data),  32'(expWord[k]));
            checkOutput("seq_valid", 32'(outBus.out_valid), 32'h1);
            step = 1'b0;
            applyStimulus();
        end
        checkOutput("ctrl_first", 32'(dut.ctrl_q), 32'h01);

        // Full data period from seed 0.
        seedLoad = 1'b1; seedIn = 16'h0000;
        applyStimulus();
        seedLoad = 1'b0; step = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            outBus.out_ready = 1'($urandom);
            applyStimulus();
        end
        step = 1'b0;
        checkOutput("period", 32'(dut.data_q), 32'h0000);

        // Prescaler-paced mode after reset release.
        rst_n = 1'b0; mode = 1'b0; outBus.out_ready = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            applyStimulus();
            if (c < 4) checkOutput("m0_early", 32'(outBus.out_valid), 32'h0);
            if (c == 4 || c == 8) checkOutput("m0_tick", 32'(tickOut), 32'h1);
            if (c == 4) checkOutput("m0_step", 32'(outBus.out_valid), 32'h1);
        end

        // Enable low freezes everything.
        heldWord = outBus.out_data; heldValid = outBus.out_valid; heldOver = overrun;
        ena = 1'b0; seedLoad = 1'b1; mode = 1'b1; step = 1'b1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            checkOutput("hold_tick",  32'(tickOut),          32'h0);
            checkOutput("hold_word",  32'(outBus.out_data),  32'(heldWord));
            checkOutput("hold_valid", 32'(outBus.out_valid), 32'(heldValid));
            checkOutput("hold_over",  32'(overrun),          32'(heldOver));
        end
        ena = 1'b1; seedLoad = 1'b0; step = 1'b0;

        // Overrun on two unaccepted steps, cleared by seed load.
        seedLoad = 1'b1; seedIn = 16'h00AB;
        applyStimulus();
        seedLoad = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step = 1'b1; applyStimulus();
            step = 1'b0; applyStimulus();
        end
        checkOutput("ovr_set", 32'(overrun), 32'h1);
        seedLoad = 1'b1;
        applyStimulus();
        checkOutput("ovr_clr",   32'(overrun),          32'h0);
        checkOutput("ovr_valid", 32'(outBus.out_valid), 32'h0);

        // All-ones seed is redirected to zero; seed load wins over step.
        seedIn = 16'hFFFF;
        applyStimulus();
        checkOutput("seed_ones", 32'(dut.data_q), 32'h0000);
        seedIn = 16'h1234; step = 1'b1;
        applyStimulus();
        checkOutput("seed_step", 32'(dut.data_q), 32'h1234);
        seedLoad = 1'b0;

        // Accept and step together keep the word valid without overrun.
        outBus.out_ready = 1'b0;
        applyStimulus();
        outBus.out_ready = 1'b1;
        applyStimulus();
        checkOutput("acc_valid", 32'(outBus.out_valid), 32'h1);
        checkOutput("acc_over",  32'(overrun),          32'h0);

        // Reset in the middle of a stream.
        outBus.out_ready = 1'b0;
        applyStimulus();
        rst_n = 1'b0; step = 1'b0;
        applyStimulus();
        checkOutput("mid_valid", 32'(outBus.out_valid), 32'h0);
        checkOutput("mid_data",  32'(outBus.out_data),  32'h0);
        checkOutput("mid_over",  32'(overrun),          32'h0);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n            = ($urandom_range(0, 99) != 0);
            ena              = ($urandom_range(0, 9) != 0);
            mode             = ($urandom_range(0, 3) != 0);
            step             = 1'($urandom);
            seedLoad         = ($urandom_range(0, 19) == 0);
            seedIn           = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            outBus.out_ready = 1'($urandom);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/prng_lfsr_gen.md
# prng_lfsr_gen

Parametrised pseudo-random byte generator for the TinyTapeout PRNG top level. A WIDTH-bit XNOR Fibonacci data LFSR and an 8-bit XNOR control LFSR feed a bit-pair selector, which produces an OUT_W-bit word. Steps come from an internal single-clock prescaler or from an external strobe, not from derived clocks. Adds seed loading, a valid/ready output handshake and overrun flagging; the output word drives the 7-segment decoders or the uio bus.

## Interface
- WIDTH, 16: data LFSR width; must be ≥ 2*OUT_W.
- TAPS, 16'hD008: data feedback mask; bit n set means state[n] is tapped.
- CTRL_TAPS, 8'hB8: control LFSR feedback mask.
- OUT_W, 8: output word width (≤ 8).
- DIV, 10_000_000: prescaler period in clk cycles (≥ 2).
- CTRL_RATIO, 4: data steps per control LFSR step (≥ 1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  design enable; low freezes state synchronously.
- mode  in  1  0 = prescaler-paced, 1 = step on `step`.
- step  in  1  single-cycle step request; used in mode 1.
- seed_load  in  1  load seed_in into the data LFSR.
- seed_in  in  WIDTH  seed value.
- out_ready  in  1  consumer accepts out_data.
- out_valid  out  1  out_data holds an unaccepted word.
- out_data  out  OUT_W  generated word.
- tick_out  out  1  one-cycle pulse on each prescaler wrap.
- overrun  out  1  sticky: an unaccepted word was overwritten.

## Operation
- Reset (rst_n low at a clk edge): data state, control state, prescaler, ratio counter, out_data, out_valid, tick_out and overrun all go to 0. Reset has priority over everything else.
- Data LFSR step: fb = ~^(state & TAPS); next = {state[WIDTH-2:0], fb}. The all-ones state is the lockup state.
- Control LFSR: same rule with CTRL_TAPS over 8 bits. It steps on every CTRL_RATIO-th data step; the ratio counter runs 0..CTRL_RATIO-1 and then wraps.
- Output selection: out_data[i] = ctrl[i] ? state[2i+1] : state[2i]. The selection uses the post-step data and control values.
- Prescaler: counts 0..DIV-1 while ena=1. At count DIV-1 it wraps to 0 and tick_out pulses. It runs in both modes.
- Step source: in mode 0, tick_out; in mode 1, step. Steps only occur when ena=1.
- seed_load (ena=1):
  - Data state loads seed_in; an all-ones seed_in loads 0 instead, so lockup is unreachable.
  - Control state, ratio counter and overrun clear to 0.
  - out_valid clears.
  - A step in the same cycle is discarded.
- ena low: all state, the prescaler and the outputs hold; step and seed_load are ignored.
- Handshake:
  - Every step loads out_data and sets out_valid.
  - out_valid && out_ready with no step clears out_valid.
  - Accept and step in the same cycle: out_valid stays 1 with the new word; overrun is not set.
  - Step while out_valid=1 and out_ready=0: the word is overwritten and overrun sets. Overrun stays set until reset or seed_load.

## Timing
- All registers update on the rising clk edge.
- A step qualified at edge k updates the data state, control state, out_data and out_valid at edge k, i.e. zero extra latency.
- Mode 0: the first step comes DIV cycles after reset release or after ena rises from a cleared prescaler; after that, one step every DIV cycles.
- Mode 1: a step held high for N cycles gives N steps.
- tick_out is high for exactly one cycle per DIV cycles while ena=1.
- Period: with default taps, the data LFSR repeats every 65535 steps and the control LFSR every 255 control steps.
- Priority per edge: reset > ena low > seed_load > step > accept.

## Test plan
- Reset then mode=1, seed 0, three step pulses -> data state 0x0001, 0x0003, 0x0007; out_data 0x01, 0x01, 0x03; out_valid 1 after each step.
- Fourth step (CTRL_RATIO=4) -> control state 0x01, data state 0x000F, out_data 0x03. 65535 steps from seed 0 -> data state returns to 0x0000.
- Mode 0 with DIV=4 -> tick_out pulses every 4 cycles; the first step lands 4 cycles after reset release. ena low for 10 cycles -> no ticks, all outputs hold.
- out_ready=0, two steps -> overrun=1, out_data holds the second word. seed_load -> overrun=0, out_valid=0.
- seed_in=0xFFFF with seed_load -> data state 0x0000. seed_load and step in the same cycle -> loaded seed is kept and no step is taken.
- rst_n low mid-stream while out_valid=1 -> next edge: all outputs 0. Accept and step in the same cycle -> out_valid stays 1 and overrun stays 0.
